// File: rtl/uart_pkg.sv
// Shared types and defaults for the host-side UART receive path.
// Pure declarations: no logic, no latency, no flow control.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_rx_state_t;

    localparam int UART_BAUD_DIV  = 868;
    localparam int UART_DATA_BITS = 8;

    // Both synchronizer stages come out of reset at the idle line level.
    localparam logic [1:0] UART_SYNC_RST = 2'b11;

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchronizer with a configurable reset value.
// Latency: 2 cycles from d to q; no backpressure (free-running sampler).
module sync_2ff
    import uart_pkg::*;
#(
    parameter logic [1:0] RST_VAL = UART_SYNC_RST
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[0], d};
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync_q <= RST_VAL;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// Oversampling 8N1 UART receiver with a one-entry ready/valid holding register.
// Latency: byte valid one cycle after mid-stop sample; a full register drops new bytes and sets sticky overrun.
module uart_rx
    import uart_pkg::*;
#(
    parameter int BAUD_DIV  = UART_BAUD_DIV,
    parameter int DATA_BITS = UART_DATA_BITS
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 io_rx,
    output logic [DATA_BITS-1:0] io_data,
    output logic                 io_valid,
    input  logic                 io_ready,
    output logic                 io_frameErr,
    output logic                 io_overrun
);

    localparam int CNT_W = $clog2(BAUD_DIV);
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    logic rxs;

    sync_2ff #(
        .RST_VAL (UART_SYNC_RST)
    ) u_sync (
        .clock (clock),
        .reset (reset),
        .d     (io_rx),
        .q     (rxs)
    );

    uart_rx_state_t       state_q,     state_d;
    logic [CNT_W-1:0]     cnt_q,       cnt_d;
    logic [IDX_W-1:0]     idx_q,       idx_d;
    logic [DATA_BITS-1:0] shreg_q,     shreg_d;
    logic [DATA_BITS-1:0] data_q,      data_d;
    logic                 valid_q,     valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q,   overrun_d;

    logic cnt_zero;
    logic consume;

    assign cnt_zero = (cnt_q == '0);
    assign consume  = valid_q & io_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shreg_d     = shreg_q;
        data_d      = data_q;
        valid_d     = valid_q;
        frame_err_d = 1'b0;
        overrun_d   = overrun_q;

        // A write from the STOP branch below overrides this clear.
        if (consume) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (!rxs) begin
                    cnt_d   = CNT_HALF;
                    state_d = START;
                end
            end

            START: begin
                if (cnt_zero) begin
                    if (rxs) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d   = CNT_FULL;
                        idx_d   = '0;
                        state_d = DATA;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            DATA: begin
                if (cnt_zero) begin
                    shreg_d = {rxs, shreg_q[DATA_BITS-1:1]};
                    cnt_d   = CNT_FULL;
                    idx_d   = idx_q + IDX_ONE;
                    if (idx_q == IDX_LAST) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            STOP: begin
                if (cnt_zero) begin
                    // Leave mid-stop-bit so a back-to-back start edge is not missed.
                    state_d = IDLE;
                    if (rxs) begin
                        if (!valid_q || io_ready) begin
                            data_d  = shreg_q;
                            valid_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shreg_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shreg_q     <= shreg_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign io_data     = data_q;
    assign io_valid    = valid_q;
    assign io_frameErr = frame_err_q;
    assign io_overrun  = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at BAUD_DIV=16, DATA_BITS=8: vector table, corner sequences, random frames.
module tb_uart_rx;

    localparam int BD  = 16;
    localparam int LAT = 3 + BD / 2 + 9 * BD;  // 155 cycles from first low sample to io_valid

    logic       clk = 1'b0;
    logic       reset;
    logic       io_rx;
    logic [7:0] io_data;
    logic       io_valid;
    logic       io_ready;
    logic       io_frameErr;
    logic       io_overrun;

    int cyc      = 0;
    int checks   = 0;
    int failures = 0;

    // Observed events, stamped with the edge number at which they are first visible.
    int         got_ts[$];
    logic [7:0] got_dat[$];
    int         ferr_ts[$];
    logic       pv = 1'b0;

    typedef struct {
        logic [7:0] dat;
        logic       stop;
        logic       exp_vld;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    uart_rx #(
        .BAUD_DIV  (BD),
        .DATA_BITS (8)
    ) dut (
        .clock       (clk),
        .reset       (reset),
        .io_rx       (io_rx),
        .io_data     (io_data),
        .io_valid    (io_valid),
        .io_ready    (io_ready),
        .io_frameErr (io_frameErr),
        .io_overrun  (io_overrun)
    );

    // A new byte is visible when valid rises, or stays high right after a handshake.
    always begin
        @(posedge clk);
        #1;
        if (io_valid === 1'b1 && (!pv || io_ready === 1'b1)) begin
            got_ts.push_back(cyc + 1);
            got_dat.push_back(io_data);
        end
        if (io_frameErr === 1'b1) ferr_ts.push_back(cyc + 1);
        pv = (io_valid === 1'b1);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cyc=%0d)", nm, act, exp, cyc);
        end
    endtask

    // Caller is at a negedge; the frame's t0 is the next posedge.
    task automatic send_frame(input logic [7:0] d, input logic stop);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            io_rx = bits[i];
            repeat (BD) @(negedge clk);
        end
        io_rx = 1'b1;
    endtask

    task automatic clear_events();
        got_ts.delete();
        got_dat.delete();
        ferr_ts.delete();
    endtask

    task automatic check_frame(input string tag, input int t0, input logic [7:0] d,
                               input logic exp_vld, input logic exp_ferr);
        chk({tag, "_nbytes"}, got_ts.size(), {31'd0, exp_vld});
        chk({tag, "_nferr"}, ferr_ts.size(), {31'd0, exp_ferr});
        if (exp_vld && got_ts.size() > 0) begin
            chk({tag, "_latency"}, got_ts[0], t0 + LAT);
            chk({tag, "_data"}, {24'd0, got_dat[0]}, {24'd0, d});
        end
        if (exp_ferr && ferr_ts.size() > 0) begin
            chk({tag, "_ferr_latency"}, ferr_ts[0], t0 + LAT);
        end
        clear_events();
    endtask

    initial begin
        int         t0;
        logic [7:0] d;
        logic       stop;
        logic       prev_bad;
        int         gap;

        vecs[0] = '{8'h55, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{8'h00, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{8'h80, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{8'h01, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{8'hFF, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{8'hA5, 1'b0, 1'b0, 1'b1};

        reset    = 1'b0;
        io_rx    = 1'b1;
        io_ready = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_valid",   {31'd0, io_valid},    32'd0);
        chk("rst_data",    {24'd0, io_data},     32'd0);
        chk("rst_ferr",    {31'd0, io_frameErr}, 32'd0);
        chk("rst_overrun", {31'd0, io_overrun},  32'd0);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        clear_events();

        // Vector table, consumer always ready.
        for (int i = 0; i < 7; i++) begin
            t0 = cyc + 1;
            send_frame(vecs[i].dat, vecs[i].stop);
            check_frame($sformatf("vec%0d", i), t0, vecs[i].dat, vecs[i].exp_vld, vecs[i].exp_ferr);
            chk($sformatf("vec%0d_valid_after", i), {31'd0, io_valid}, 32'd0);
            chk($sformatf("vec%0d_overrun", i), {31'd0, io_overrun}, 32'd0);
            repeat (24) @(negedge clk);
        end

        // Short low glitch rejected at mid-start, then a real byte.
        io_rx = 1'b0;
        repeat (4) @(negedge clk);
        io_rx = 1'b1;
        repeat (40) @(negedge clk);
        chk("glitch_nbytes", got_ts.size(), 32'd0);
        chk("glitch_nferr", ferr_ts.size(), 32'd0);
        chk("glitch_valid", {31'd0, io_valid}, 32'd0);
        clear_events();
        t0 = cyc + 1;
        send_frame(8'h3C, 1'b1);
        check_frame("after_glitch", t0, 8'h3C, 1'b1, 1'b0);
        repeat (24) @(negedge clk);

        // Held byte replaced on the exact cycle it is consumed.
        io_ready = 1'b0;
        t0 = cyc + 1;
        send_frame(8'h11, 1'b1);
        check_frame("hold11", t0, 8'h11, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        t0 = cyc + 1;
        fork
            send_frame(8'h22, 1'b1);
            begin
                while (cyc < t0 + LAT - 2) @(negedge clk);
                chk("held11_valid", {31'd0, io_valid}, 32'd1);
                chk("held11_data", {24'd0, io_data}, 32'h11);
                io_ready = 1'b1;
                @(negedge clk);
                io_ready = 1'b0;
            end
        join
        check_frame("simul22", t0, 8'h22, 1'b1, 1'b0);
        chk("simul_valid", {31'd0, io_valid}, 32'd1);
        chk("simul_data", {24'd0, io_data}, 32'h22);
        chk("simul_overrun", {31'd0, io_overrun}, 32'd0);
        io_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("consume_clears", {31'd0, io_valid}, 32'd0);
        @(negedge clk);
        repeat (10) @(negedge clk);
        clear_events();

        // Random frames against the frame-level reference model.
        prev_bad = 1'b0;
        for (int n = 0; n < 12; n++) begin
            gap = prev_bad ? 24 : $urandom_range(0, 20);
            repeat (gap) @(negedge clk);
            d    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 4) != 0);
            t0   = cyc + 1;
            send_frame(d, stop);
            check_frame($sformatf("rnd%0d", n), t0, d, stop, !stop);
            prev_bad = !stop;
        end
        repeat (24) @(negedge clk);
        chk("rnd_overrun", {31'd0, io_overrun}, 32'd0);
        clear_events();

        // Back-to-back with no consumer: second byte dropped, overrun sticks.
        io_ready = 1'b0;
        t0 = cyc + 1;
        send_frame(8'hA3, 1'b1);
        send_frame(8'h0F, 1'b1);
        check_frame("b2b", t0, 8'hA3, 1'b1, 1'b0);
        chk("b2b_overrun", {31'd0, io_overrun}, 32'd1);
        chk("b2b_valid", {31'd0, io_valid}, 32'd1);
        chk("b2b_data", {24'd0, io_data}, 32'hA3);
        repeat (24) @(negedge clk);

        // Reset during data bit 3, held until the line is idle again.
        t0 = cyc + 1;
        fork
            send_frame(8'h81, 1'b1);
            begin
                while (cyc < t0 + 70) @(negedge clk);
                reset = 1'b0;
                @(posedge clk);
                #1;
                chk("midrst_valid",   {31'd0, io_valid},    32'd0);
                chk("midrst_data",    {24'd0, io_data},     32'd0);
                chk("midrst_ferr",    {31'd0, io_frameErr}, 32'd0);
                chk("midrst_overrun", {31'd0, io_overrun},  32'd0);
            end
        join
        reset    = 1'b1;
        io_ready = 1'b1;
        repeat (24) @(negedge clk);
        chk("midrst_no_bytes", got_ts.size(), 32'd0);
        clear_events();
        t0 = cyc + 1;
        send_frame(8'h81, 1'b1);
        check_frame("resend81", t0, 8'h81, 1'b1, 1'b0);
        chk("resend_overrun", {31'd0, io_overrun}, 32'd0);
        repeat (10) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Host-side UART receiver: the deserializing counterpart to the NeuromorphicProcessor's `io_uartTx` output. It oversamples a serial 8N1 line, validates start and stop bits, and presents each received byte on a ready/valid port to host-side logic such as a debug bridge, spike-readout FIFO or test harness. It sits beside the processor in the FPGA top level on the same clock, with its `io_rx` driven by the processor's TX pin or the board UART RX pin.

## Interface
- `BAUD_DIV`, default 868: clock cycles per bit (100 MHz / 115200). Must be even and at least 8.
- `DATA_BITS`, default 8: data bits per frame. LSB is first on the line.
- `clock`, in, 1: single system clock. All logic is on its rising edge.
- `reset`, in, 1: synchronous, active-low. The block is in reset while `reset`=0.
- `io_rx`, in, 1: asynchronous serial input. Idle level is 1.
- `io_data`, out, DATA_BITS: received byte. Valid only while `io_valid`=1.
- `io_valid`, out, 1: holding register contains an unconsumed byte.
- `io_ready`, in, 1: consumer accepts the byte. A transfer occurs on any cycle with `io_valid` & `io_ready`.
- `io_frameErr`, out, 1: one-cycle pulse when the stop bit is sampled as 0.
- `io_overrun`, out, 1: sticky flag. Set when a byte completes while the holding register is still full. Cleared only by reset.

## Operation
- **Synchronizer:** `io_rx` passes through a 2-flop synchronizer. Only the synchronized signal `rxs` is used downstream. Both flops reset to 1.
- **FSM states:** IDLE, START, DATA, STOP. Reset state is IDLE.
- **Counters:** a bit-period counter `cnt` of width clog2(BAUD_DIV), and a bit index `idx` of width clog2(DATA_BITS).
- **IDLE:** when `rxs`=0, load `cnt`=BAUD_DIV/2−1 and go to START.
- **START:** decrement `cnt`. When `cnt`=0, sample `rxs`.
  - If `rxs`=1: glitch. Return to IDLE with no output.
  - If `rxs`=0: load `cnt`=BAUD_DIV−1, set `idx`=0, go to DATA.
- **DATA:** when `cnt`=0, shift `rxs` into the shift register MSB-side (LSB-first frame), reload `cnt`, and increment `idx`. After bit DATA_BITS−1 is sampled, go to STOP with `cnt`=BAUD_DIV−1.
- **STOP:** at `cnt`=0, sample the stop bit and return to IDLE immediately (mid-stop-bit), so back-to-back frames are received.
  - Stop=1 and holding register empty, or being consumed this same cycle: write the shift register to `io_data` and set `io_valid`.
  - Stop=1 and holding register full, not consumed this cycle: keep the old byte, drop the new one, set `io_overrun`.
  - Stop=0: pulse `io_frameErr`, drop the byte. `io_valid` and `io_data` are unchanged.
- **Consume:** `io_valid`&`io_ready` with no simultaneous write clears `io_valid`. With a simultaneous write, `io_valid` stays 1 and `io_data` takes the new byte.
- **Reset values:** `io_data`=0, `io_valid`=0, `io_frameErr`=0, `io_overrun`=0. The shift register, `cnt` and `idx` are all 0.
- **Reset mid-frame:** the partial frame is discarded. After reset releases, the block resynchronizes on the next falling edge of `rxs`. A line held low through reset release is seen as a start bit, and is then rejected at mid-start only if it has risen by then.

## Timing
- Let t0 be the clock edge at which `io_rx` is first sampled 0.
  - `rxs`=0 at t0+2. FSM enters START at t0+3.
  - Start is sampled at t0+2+BAUD_DIV/2.
  - Data bit k is sampled at t0+2+BAUD_DIV/2+(k+1)·BAUD_DIV.
  - `io_valid` is first high at t0+3+BAUD_DIV/2+(DATA_BITS+1)·BAUD_DIV.
- `io_frameErr` is high for exactly one cycle, at the same edge where `io_valid` would have risen.
- `io_data` is stable while `io_valid`=1 and not consumed.
- Consumption takes effect in one cycle: `io_valid` falls on the edge after the handshake cycle.
- Tolerates ±4% baud mismatch, because sampling is at bit centre.

## Structure
- Package `uart_pkg`:
  - `uart_rx_state_t` enum (IDLE/START/DATA/STOP).
  - Default constants `UART_BAUD_DIV`=868 and `UART_DATA_BITS`=8.
  - The 2-bit sync reset constant.
- Sub-module `sync_2ff`: a generic 1-bit, 2-flop synchronizer with a reset value parameter. It is reused later for the `io_uartRx` side of a matching host transmitter.
- Everything else is one FSM plus the datapath in `uart_rx`.

## Test plan
All scenarios use BAUD_DIV=16 and DATA_BITS=8, which gives `io_valid` at t0+155.
- **Single byte:** send 0x55 with `io_ready`=1 → `io_valid` pulses once at t0+155 with `io_data`=0x55. `io_frameErr`=0 and `io_overrun`=0.
- **Back-to-back:** send 0xA3 then 0x0F with no idle gap, `io_ready` held 0 until both complete, then 1 → first byte 0xA3 delivered; 0x0F dropped and `io_overrun`=1.
- **Framing error:** send 0xFF with stop bit 0 → `io_frameErr` high one cycle at t0+155. `io_valid` stays 0.
- **Glitch:** drive `io_rx` low for 4 cycles then high → FSM returns to IDLE at start sample. No outputs change. A following 0x3C is received correctly.
- **Simultaneous consume and write:** `io_valid`=1 with 0x11 held, and `io_ready` rises on the exact cycle 0x22 completes → `io_valid` stays 1, `io_data`=0x22, `io_overrun`=0.
- **Reset mid-frame:** assert `reset`=0 during bit 3 of 0x81 → all outputs return to 0 on the next edge. After release, 0x81 resent is received correctly.
